// File: rtl/mult_hilo_pkg.sv
// Shared types and constants for the MIPS HI/LO multiply controller.
package mult_hilo_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned ProdW = 64;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MFHI  = 3'd2,
    OP_MFLO  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MADDU = 3'd7
  } op_code_e;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  // Two's complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [DataW-1:0] mag(input logic [DataW-1:0] x);
    return x[DataW-1] ? -x : x;
  endfunction

endpackage

// File: rtl/mult_hilo_ctrl_if.sv
// Pipeline <-> HI/LO controller op request and read-back bus.
interface mult_hilo_ctrl_if;
  import mult_hilo_pkg::*;

  logic             op_valid;
  logic [2:0]       op_code;
  logic [DataW-1:0] op_a;
  logic [DataW-1:0] op_b;
  logic             op_ready;
  logic             rd_valid;
  logic [DataW-1:0] rd_data;

  modport master (
    output op_valid, op_code, op_a, op_b,
    input  op_ready, rd_valid, rd_data
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b,
    output op_ready, rd_valid, rd_data
  );

endinterface

// File: rtl/multiplier32bit_single_stage.sv
// Single-stage 32x32 unsigned combinational multiplier (multicycle path).
module multiplier32bit_single_stage
  import mult_hilo_pkg::*;
(
  input  logic [DataW-1:0] a,
  input  logic [DataW-1:0] b,
  output logic [ProdW-1:0] p
);

  // Zero-extend both operands so the product is a full 64-bit unsigned result
  always_comb p = {{DataW{1'b0}}, a} * {{DataW{1'b0}}, b};

endmodule

// File: rtl/mult_hilo_ctrl.sv
// HI/LO sequencing controller around a multicycle 32x32 multiplier.
// Optional macro MULT_ACC_EN enables MADD/MADDU (op codes 6/7) accumulate.
module mult_hilo_ctrl
  import mult_hilo_pkg::*;
#(
  parameter int unsigned LATENCY = 2  // legal 1..8
) (
  input  logic             clk,
  input  logic             rst,
  mult_hilo_ctrl_if.slave  bus,
  output logic             busy,
  output logic             mul_done,
  output logic [DataW-1:0] hi,
  output logic [DataW-1:0] lo
);

  localparam logic [2:0] CntInit = 3'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [2:0]       cnt_q;
  logic [DataW-1:0] a_q, b_q;
  logic             neg_q;
  logic [DataW-1:0] hi_q, lo_q;
  logic [DataW-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             mul_done_q;

  op_code_e         code;
  logic             accept;
  logic             start_mul;
  logic             is_signed;
  logic [ProdW-1:0] prod;
  logic [ProdW-1:0] fixed;
  logic [ProdW-1:0] result;

  assign code   = op_code_e'(bus.op_code);
  assign accept = bus.op_valid && bus.op_ready;

`ifdef MULT_ACC_EN
  logic acc_q;

  assign start_mul = accept && (code == OP_MULT || code == OP_MULTU ||
                                code == OP_MADD || code == OP_MADDU);
  assign is_signed = (code == OP_MULT) || (code == OP_MADD);
`else
  assign start_mul = accept && (code == OP_MULT || code == OP_MULTU);
  assign is_signed = (code == OP_MULT);
`endif

  multiplier32bit_single_stage u_mul (
    .a (a_q),
    .b (b_q),
    .p (prod)
  );

  // Sign fix-up (and optional accumulate) of the unsigned magnitude product
  always_comb begin
    fixed = neg_q ? -prod : prod;
`ifdef MULT_ACC_EN
    result = acc_q ? ({hi_q, lo_q} + fixed) : fixed;
`else
    result = fixed;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_mul) state_d = CALC;
      CALC: if (cnt_q == 3'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: only IDLE accepts ops
  always_comb begin
    bus.op_ready = (state_q == IDLE);
    busy         = (state_q == CALC);
  end

  // Datapath: operand latch, countdown, HI/LO and read-back registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 3'd0;
      a_q        <= '0;
      b_q        <= '0;
      neg_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      mul_done_q <= 1'b0;
`ifdef MULT_ACC_EN
      acc_q      <= 1'b0;
`endif
    end else begin
      rd_valid_q <= 1'b0;
      mul_done_q <= 1'b0;
      if (start_mul) begin
        // Operands stay frozen for all of CALC: the multiplier is a multicycle path
        a_q   <= is_signed ? mag(bus.op_a) : bus.op_a;
        b_q   <= is_signed ? mag(bus.op_b) : bus.op_b;
        neg_q <= is_signed && (bus.op_a[DataW-1] ^ bus.op_b[DataW-1]);
        cnt_q <= CntInit;
`ifdef MULT_ACC_EN
        acc_q <= (code == OP_MADD) || (code == OP_MADDU);
`endif
      end else if (state_q == CALC) begin
        if (cnt_q != 3'd0) begin
          cnt_q <= cnt_q - 3'd1;
        end else begin
          {hi_q, lo_q} <= result;
          mul_done_q   <= 1'b1;
        end
      end
      if (accept) begin
        unique case (code)
          OP_MFHI: begin
            rd_data_q  <= hi_q;
            rd_valid_q <= 1'b1;
          end
          OP_MFLO: begin
            rd_data_q  <= lo_q;
            rd_valid_q <= 1'b1;
          end
          OP_MTHI: hi_q <= bus.op_a;
          OP_MTLO: lo_q <= bus.op_a;
          default: ;
        endcase
      end
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign mul_done     = mul_done_q;
  assign hi           = hi_q;
  assign lo           = lo_q;

endmodule
